// File: rtl/sr_stack_fifo_pkg.sv
// Shared constants and types for the CPU push/pop FIFO.
package sr_stack_fifo_pkg;

   // Default geometry of the fifoIn buffer next to sr_cpu
   localparam int SR_FIFO_DEPTH = 8;
   localparam int SR_FIFO_WIDTH = 32;

   // Sticky error flags reported back to software
   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

   // Sticky flag update: a new error in the same cycle beats a clear
   function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
      return set | (cur & ~clr);
   endfunction

endpackage

// File: rtl/sr_fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module sr_fifo_ram
   import sr_stack_fifo_pkg::*;
#(
   parameter int WIDTH = SR_FIFO_WIDTH,
   parameter int DEPTH = SR_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the addressed entry on an accepted push
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Zero-latency head read so the core can write back in the same cycle
   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/sr_stack_fifo.sv
// Responder for the CPU push/pop custom instructions: a FIFO whose head
// word is presented combinationally, with sticky overflow/underflow flags.
module sr_stack_fifo
   import sr_stack_fifo_pkg::*;
#(
   parameter int WIDTH = SR_FIFO_WIDTH,
   parameter int DEPTH = SR_FIFO_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow,
   input  logic             errClear
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fifo_err_t        err_q, err_d;

   logic             full_w, empty_w;
   logic             push_ok, pop_ok;
   logic [WIDTH-1:0] ram_rdata;

   // Occupancy decode straight off the registered count
   always_comb begin
      full_w  = (count_q == CNT_W'(DEPTH));
      empty_w = (count_q == '0);
   end

   // Accept rules: a push into a full FIFO is fine if a pop frees a slot
   // this same edge; a pop never sees a same-cycle push (no bypass).
   always_comb begin
      push_ok = push & (~full_w | pop);
      pop_ok  = pop & ~empty_w;
   end

   // Next-state for pointers, occupancy and sticky flags
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end

      err_d.overflow  = sticky_next(err_q.overflow,  push & ~push_ok, errClear);
      err_d.underflow = sticky_next(err_q.underflow, pop & ~pop_ok,   errClear);
   end

   // State registers; reset discards queued data by zeroing the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // When full, wr_ptr == rd_ptr: the write lands in the slot being
   // freed, and the read port still shows the old head until the edge.
   sr_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr_q),
      .wdata (pushData),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // Outputs; an empty FIFO reads as zero rather than stale storage
   always_comb begin
      popData   = empty_w ? '0 : ram_rdata;
      full      = full_w;
      empty     = empty_w;
      count     = count_q;
      overflow  = err_q.overflow;
      underflow = err_q.underflow;
   end

endmodule

// File: tb/tb_sr_stack_fifo.sv
// Bench for sr_stack_fifo: table vectors with hand-derived expectations,
// backed by a queue scoreboard checked every cycle.
module tb_sr_stack_fifo;

   localparam int W  = 32;
   localparam int D  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          push, pop, errClear;
   logic [W-1:0]  pushData;
   logic [W-1:0]  popData;
   logic          full, empty, overflow, underflow;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   int unsigned model_q[$];
   bit          m_ovf, m_udf;

   typedef struct {
      bit          push;
      bit          pop;
      bit          clr;
      logic [31:0] data;
      logic [31:0] e_pd;
      int          e_cnt;
      bit          e_udf;
   } tvec_t;

   tvec_t tab[17];

   sr_stack_fifo #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pushData  (pushData),
      .pop       (pop),
      .popData   (popData),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .errClear  (errClear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle; check outputs at negedge against the scoreboard
   // (and optional hand-derived values), then advance the model.
   task automatic step(input bit p, input bit q, input bit c, input logic [31:0] d,
                       input bit has_exp, input logic [31:0] e_pd, input int e_cnt,
                       input bit e_udf);
      bit p_ok, q_ok;
      int sz;
      push = p; pop = q; errClear = c; pushData = d;
      @(negedge clk);
      sz = model_q.size();
      chk("count",     {28'd0, count}, sz);
      chk("empty",     {31'd0, empty}, (sz == 0) ? 1 : 0);
      chk("full",      {31'd0, full},  (sz == D) ? 1 : 0);
      chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
      chk("underflow", {31'd0, underflow}, {31'd0, m_udf});
      chk("popData",   popData, (sz > 0) ? model_q[0] : 32'd0);
      if (has_exp) begin
         chk("tab_popData",   popData, e_pd);
         chk("tab_count",     {28'd0, count}, e_cnt);
         chk("tab_underflow", {31'd0, underflow}, {31'd0, e_udf});
      end
      q_ok = q && (sz > 0);
      p_ok = p && ((sz < D) || q);
      @(posedge clk);
      #1;
      if (q_ok) void'(model_q.pop_front());
      if (p_ok) model_q.push_back(d);
      m_ovf = (p && !p_ok) || (m_ovf && !c);
      m_udf = (q && !q_ok) || (m_udf && !c);
   endtask

   task automatic run(input bit p, input bit q, input bit c, input logic [31:0] d);
      step(p, q, c, d, 1'b0, 32'd0, 0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; push = 1'b0; pop = 1'b0; errClear = 1'b0; pushData = '0;
      m_ovf = 1'b0; m_udf = 1'b0;

      // Reset state
      #3;
      chk("rst_count",     {28'd0, count}, 0);
      chk("rst_empty",     {31'd0, empty}, 1);
      chk("rst_full",      {31'd0, full}, 0);
      chk("rst_overflow",  {31'd0, overflow}, 0);
      chk("rst_underflow", {31'd0, underflow}, 0);
      chk("rst_popData",   popData, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Expectations observed before the edge of each vector
      tab[0]  = '{1, 0, 0, 32'h11, 32'h00, 0, 0};
      tab[1]  = '{1, 0, 0, 32'h22, 32'h11, 1, 0};
      tab[2]  = '{1, 0, 0, 32'h33, 32'h11, 2, 0};
      tab[3]  = '{0, 1, 0, 32'h00, 32'h11, 3, 0};
      tab[4]  = '{0, 1, 0, 32'h00, 32'h22, 2, 0};
      tab[5]  = '{0, 1, 0, 32'h00, 32'h33, 1, 0};
      tab[6]  = '{0, 0, 0, 32'h00, 32'h00, 0, 0};
      tab[7]  = '{0, 1, 0, 32'h00, 32'h00, 0, 0};
      tab[8]  = '{0, 0, 1, 32'h00, 32'h00, 0, 1};
      tab[9]  = '{0, 0, 0, 32'h00, 32'h00, 0, 0};
      tab[10] = '{1, 1, 0, 32'h05, 32'h00, 0, 0};
      tab[11] = '{0, 0, 0, 32'h00, 32'h05, 1, 1};
      tab[12] = '{0, 1, 1, 32'h00, 32'h05, 1, 1};
      tab[13] = '{0, 0, 0, 32'h00, 32'h00, 0, 0};
      tab[14] = '{0, 1, 1, 32'h00, 32'h00, 0, 0};
      tab[15] = '{0, 0, 1, 32'h00, 32'h00, 0, 1};
      tab[16] = '{0, 0, 0, 32'h00, 32'h00, 0, 0};
      for (int i = 0; i < 17; i++) begin
         step(tab[i].push, tab[i].pop, tab[i].clr, tab[i].data,
              1'b1, tab[i].e_pd, tab[i].e_cnt, tab[i].e_udf);
      end

      // Fill to DEPTH, refused push, drain
      for (int i = 1; i <= D; i++) run(1, 0, 0, i);
      chk("fill_full", {31'd0, full}, 1);
      run(1, 0, 0, 32'h99);
      chk("ovf_set",   {31'd0, overflow}, 1);
      chk("ovf_count", {28'd0, count}, D);
      for (int i = 0; i < D; i++) run(0, 1, 0, 0);
      run(0, 0, 1, 0);
      run(0, 0, 0, 0);

      // Full with simultaneous push/pop, then drain across the wrap
      for (int i = 1; i <= D; i++) run(1, 0, 0, i);
      step(1, 1, 0, 32'hAA, 1'b1, 32'h1, D, 1'b0);
      chk("fullpp_count", {28'd0, count}, D);
      chk("fullpp_ovf",   {31'd0, overflow}, 0);
      for (int i = 0; i < D; i++) run(0, 1, 0, 0);
      run(0, 0, 0, 0);

      // Asynchronous reset in the middle of a cycle
      for (int i = 1; i <= 4; i++) run(1, 0, 0, 32'h40 + i);
      run(0, 1, 0, 0);
      push = 1'b0; pop = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_empty",   {31'd0, empty}, 1);
      chk("arst_count",   {28'd0, count}, 0);
      chk("arst_popData", popData, 0);
      pop = 1'b0;
      model_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run(1, 0, 0, 32'h7);
      step(0, 1, 0, 0, 1'b1, 32'h7, 1, 1'b0);
      run(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_stack_fifo.md
Name: sr_stack_fifo

Overview:
- Data buffer that services the CPU's `push`/`pop` custom instructions. It is the responder side of the CPU's `fifoIn` path.
- The CPU core asserts `push` with `rs1` data, or `pop` to fetch a word into its register file. This block stores words in first-in-first-out order and returns the head word combinationally, so a single-cycle core can write it back in the same cycle.
- It sits inside `sm_top`, next to `sr_cpu`, on `cpuClk`.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of entries. Must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  CPU clock (`cpuClk`); all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  push request from the decoded push instruction.
- pushData  in  WIDTH  word to store (the `rs1` value).
- pop  in  1  pop request from the decoded pop instruction.
- popData  out  WIDTH  head word; combinational.
- full  out  1  occupancy equals DEPTH.
- empty  out  1  occupancy equals 0.
- count  out  CNT_W  current occupancy, 0 to DEPTH.
- overflow  out  1  sticky: a push was refused because the FIFO was full.
- underflow  out  1  sticky: a pop was refused because the FIFO was empty.
- errClear  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async, `rst_n`=0):
  - wrPtr=0, rdPtr=0, count=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - popData=0.
  - Storage contents are not reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `popData` = mem[rdPtr] when `empty`=0; otherwise 0. It is purely combinational, with zero-cycle latency from a pointer change.
- Accept rules, evaluated on `full`/`empty` before the edge:
  - pushOk = push & (~full | pop).
  - popOk = pop & ~empty.
- Rising edge:
  - If pushOk: mem[wrPtr] <= pushData; wrPtr <= wrPtr+1.
  - If popOk: rdPtr <= rdPtr+1.
  - count <= count + pushOk - popOk.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged. The popped word is the old head.
  - Full: both accepted, count stays DEPTH, no overflow. The write lands in the slot being freed (wrPtr==rdPtr); popData in that cycle is still the old head.
  - Empty: the pop is refused (underflow set, popData=0) and the push is accepted. Next cycle count=1 and popData=pushData. There is no write-through bypass.
- Refused push (full and no pop): storage and pointers unchanged; overflow <= 1.
- Refused pop (empty): pointers unchanged; underflow <= 1.
- `errClear`: overflow/underflow <= 0 on the edge. If a new error occurs in the same cycle, set wins over clear.
- `full`/`empty` are decoded from the registered count (no extra latency relative to count).
- Reset mid-operation: all queued data is discarded (empty=1 immediately, asynchronously); the sticky flags are cleared.
- `push`/`pop` are sampled only at the rising edge; glitches between edges have no effect.

Decomposition:
- Shared header `sr_cpu.vh`, beside the existing RVOP_PUSH/RVF3_PUSH/RVOP_POP/RVF3_POP encodings:
  - `SR_FIFO_DEPTH` (8).
  - `SR_FIFO_WIDTH` (32).
- One sub-module, `sr_fifo_ram`: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, count and flag logic stays in `sr_stack_fifo`.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles → count=3, empty=0. Then pop three times → popData reads 0x11, 0x22, 0x33 in the cycles the pops are asserted; count returns to 0, empty=1, no flags set.
- Fill to DEPTH=8 with 1..8 → full=1. One more push of 0x99 → overflow=1, count=8. Pops then return 1..8 (0x99 is absent).
- From empty, pop → underflow=1, popData=0, count=0. Then errClear=1 for one cycle → underflow=0.
- Full with 1..8, simultaneous push 0xAA + pop → popData=1 that cycle, count stays 8, overflow=0. Subsequent pops return 2..8 then 0xAA, exercising pointer wrap-around.
- From empty, simultaneous push 0x5 + pop → underflow=1. Next cycle count=1, popData=0x5.
- After pushing 4 words, assert rst_n=0 mid-cycle → empty=1, count=0 and popData=0 before the next edge. After release, push 0x7 / pop returns 0x7.
